// File: rtl/layer_top_sdiv_29s_15ns_16_seq.sv
// layer_top_sdiv_29s_15ns_16_seq: restoring radix-2 signed/unsigned divider with saturating 16-bit quotient
module layer_top_sdiv_29s_15ns_16_seq #(
    parameter int DIVIDEND_WIDTH = 29,
    parameter int DIVISOR_WIDTH  = 15,
    parameter int QUOTIENT_WIDTH = 16
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] din0,
    input  logic [DIVISOR_WIDTH-1:0]  din1,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [QUOTIENT_WIDTH-1:0] dout,
    output logic [DIVISOR_WIDTH:0]    rem,
    output logic                      ovf,
    output logic                      dbz
);
    localparam int CW = $clog2(DIVIDEND_WIDTH);
    localparam logic [DIVIDEND_WIDTH-1:0] QPOS = DIVIDEND_WIDTH'((64'd1 << (QUOTIENT_WIDTH - 1)) - 64'd1);
    localparam logic [DIVIDEND_WIDTH-1:0] QNEG = QPOS + DIVIDEND_WIDTH'(1);
    localparam logic [QUOTIENT_WIDTH-1:0] SAT_POS = {1'b0, {(QUOTIENT_WIDTH-1){1'b1}}};
    localparam logic [QUOTIENT_WIDTH-1:0] SAT_NEG = {1'b1, {(QUOTIENT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state;

    logic                      sign, dbz_flag, ge, ovf_c;
    logic [DIVIDEND_WIDTH-1:0] a, din_abs;
    logic [DIVISOR_WIDTH-1:0]  d;
    logic [DIVISOR_WIDTH:0]    p, p_sh;
    logic [CW-1:0]             cnt;
    logic [QUOTIENT_WIDTH-1:0] q_lo;

    // a holds the dividend magnitude and fills with quotient bits from the bottom as it shifts out
    always_comb begin
        din_abs = din0[DIVIDEND_WIDTH-1] ? -din0 : din0;
        p_sh    = {p[DIVISOR_WIDTH-1:0], a[DIVIDEND_WIDTH-1]};
        ge      = p_sh >= {1'b0, d};
        q_lo    = a[QUOTIENT_WIDTH-1:0];
        ovf_c   = sign ? (a > QNEG) : (a > QPOS);
    end

    assign in_ready = (state == IDLE) && !ap_rst;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state     <= IDLE;
            sign      <= 1'b0;
            dbz_flag  <= 1'b0;
            a         <= '0;
            d         <= '0;
            p         <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            dout      <= '0;
            rem       <= '0;
            ovf       <= 1'b0;
            dbz       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sign     <= din0[DIVIDEND_WIDTH-1];
                    a        <= din_abs;
                    d        <= din1;
                    dbz_flag <= din1 == '0;
                    p        <= '0;
                    cnt      <= CW'(DIVIDEND_WIDTH - 1);
                    state    <= CALC;
                end
                CALC: begin
                    p     <= ge ? p_sh - {1'b0, d} : p_sh;
                    a     <= {a[DIVIDEND_WIDTH-2:0], ge};
                    cnt   <= cnt - CW'(1);
                    state <= cnt == '0 ? FIX : CALC;
                end
                FIX: begin
                    dout      <= dbz_flag ? (sign ? SAT_NEG : SAT_POS) :
                                 ovf_c    ? (sign ? SAT_NEG : SAT_POS) :
                                 sign     ? -q_lo : q_lo;
                    rem       <= dbz_flag ? '0 : sign ? -p : p;
                    ovf       <= !dbz_flag && ovf_c;
                    dbz       <= dbz_flag;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_layer_top_sdiv_29s_15ns_16_seq.sv
// tb_layer_top_sdiv_29s_15ns_16_seq: random and directed checks of the divider against an integer-division model
module tb_layer_top_sdiv_29s_15ns_16_seq;
    logic        ap_clk = 1'b0, ap_rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic [28:0] din0 = '0;
    logic [14:0] din1 = '0;
    logic        in_ready, out_valid, ovf, dbz;
    logic [15:0] dout, rem;
    int          checks = 0, failures = 0;
    longint      last_t = -1;

    layer_top_sdiv_29s_15ns_16_seq dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready),
        .din0(din0), .din1(din1), .out_valid(out_valid), .out_ready(out_ready),
        .dout(dout), .rem(rem), .ovf(ovf), .dbz(dbz)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // truncating integer division: SV '/' rounds toward zero and '%' takes the dividend's sign
    function automatic void model(input logic [28:0] a, input logic [14:0] b,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output logic o, output logic z);
        longint sa = longint'($signed(a));
        longint sb = longint'(b);
        longint qq, rr;
        if (b == 0) begin
            q = sa < 0 ? 16'h8000 : 16'h7fff; r = 16'h0; o = 1'b0; z = 1'b1;
        end else begin
            qq = sa / sb; rr = sa % sb;
            z = 1'b0;
            o = qq > 32767 || qq < -32768;
            q = qq > 32767 ? 16'h7fff : qq < -32768 ? 16'h8000 : 16'(qq);
            r = 16'(rr);
        end
    endfunction

    task automatic do_op(input logic [28:0] a, input logic [14:0] b, input int hold,
                         input logic pre, input logic [28:0] na, input logic [14:0] nb, input logic ii);
        logic [15:0] eq, er, hd, hr;
        logic        eo, ez, busy;
        int          n, lat;
        longint      acc_t;
        model(a, b, eq, er, eo, ez);
        din0 = a; din1 = b; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin @(posedge ap_clk); #1; n++; end
        check("accept_wait", in_ready, 1);
        @(posedge ap_clk);
        acc_t = longint'($time);
        if (ii && last_t >= 0) check("init_interval", (acc_t - last_t) / 10, 32);
        last_t = acc_t;
        #1;
        in_valid = 1'b0; din0 = 29'($urandom); din1 = 15'($urandom);
        busy = 1'b0; lat = 0;
        while (!out_valid && lat < 60) begin
            busy |= in_ready;
            in_valid = lat == 5;
            @(posedge ap_clk); #1; lat++;
        end
        in_valid = 1'b0;
        check("latency", lat, 30);
        check("busy_in_ready", busy, 0);
        check("dout", dout, eq);
        check("rem", rem, er);
        check("ovf", ovf, eo);
        check("dbz", dbz, ez);
        if (hold > 0) begin
            out_ready = 1'b0; hd = dout; hr = rem;
            repeat (hold) begin
                @(posedge ap_clk); #1;
                check("hold_valid", out_valid, 1);
                check("hold_in_ready", in_ready, 0);
                check("hold_dout", dout, hd);
                check("hold_rem", rem, hr);
            end
        end
        if (pre) begin din0 = na; din1 = nb; in_valid = 1'b1; end
        out_ready = 1'b1;
        @(posedge ap_clk); #1;
        check("release_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
    endtask

    logic [28:0] ra[21];
    logic [14:0] rb[21];
    logic        stale;

    initial begin
        #1 check("rst_in_ready", in_ready, 0);
        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_rem", rem, 0);
        check("rst_flags", {ovf, dbz}, 0);
        check("rst_in_ready_held", in_ready, 0);
        #2 ap_rst = 1'b0;
        #1 check("post_rst_in_ready", in_ready, 1);

        do_op(29'd1000, 15'd7, 0, 0, 0, 0, 0);
        check("spec_1000_7", {dout, rem}, {16'd142, 16'd6});
        do_op(29'(-1000), 15'd7, 0, 0, 0, 0, 0);
        check("spec_m1000_7", {dout, rem}, {16'(-142), 16'(-6)});
        do_op(29'h0fffffff, 15'd32767, 0, 0, 0, 0, 0);
        check("spec_max_div", {dout, rem, ovf}, {16'd8192, 16'd8191, 1'b0});
        do_op(29'h10000000, 15'd1, 0, 0, 0, 0, 0);
        check("spec_min_sat", {dout, rem, ovf}, {16'h8000, 16'd0, 1'b1});
        do_op(29'd5, 15'd0, 0, 0, 0, 0, 0);
        do_op(29'(-5), 15'd0, 0, 0, 0, 0, 0);
        do_op(29'(-32768), 15'd1, 0, 0, 0, 0, 0);
        do_op(29'(-32769), 15'd1, 0, 0, 0, 0, 0);
        do_op(29'd32768, 15'd1, 0, 0, 0, 0, 0);
        do_op(29'd12345, 15'd17, 5, 0, 0, 0, 0);

        din0 = 29'd99999; din1 = 15'd3; in_valid = 1'b1;
        @(posedge ap_clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge ap_clk);
        #3 ap_rst = 1'b1;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 0);
        @(posedge ap_clk);
        #4 ap_rst = 1'b0;
        #1 check("abort_release_ready", in_ready, 1);
        stale = 1'b0;
        repeat (40) begin @(posedge ap_clk); #1; stale |= out_valid; end
        check("no_stale_result", stale, 0);
        do_op(29'(-77777), 15'd123, 0, 0, 0, 0, 0);

        for (int i = 0; i < 21; i++) begin
            case ($urandom_range(0, 7))
                0: rb[i] = 15'd0;
                1: rb[i] = 15'd1;
                2, 3: rb[i] = 15'($urandom_range(1, 100));
                default: rb[i] = 15'($urandom);
            endcase
            ra[i] = $urandom_range(0, 3) == 0 ? 29'($signed(17'($urandom))) : 29'($urandom);
        end
        for (int i = 0; i < 20; i++) do_op(ra[i], rb[i], 0, 1, ra[i+1], rb[i+1], i > 0);
        in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
